// File: rtl/payload_pkg.sv
// Shared definitions for the payload slot pool: tag width derivation,
// per-slot occupancy state and the default low-water threshold.
package payload_pkg;

  localparam int LOW_WM_DEFAULT = 4;

  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_USED = 1'b1
  } slot_state_e;

  // Tag width for a pool of 'slots' entries (never narrower than one bit).
  function automatic int tag_w(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/payload_rr_arbiter.sv
// CH-wide round-robin arbiter. The grant is combinational; the rotating
// pointer advances past the winner only when the grant is accepted.
module payload_rr_arbiter #(
  parameter int  CH    = 2,
  localparam int PTR_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CH-1:0]    req,
  input  logic             en,
  input  logic             accept,
  output logic [CH-1:0]    gnt,
  output logic [PTR_W-1:0] win
);

  logic [PTR_W-1:0] rr_q, rr_d;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Cyclic search for the first requester at or after the pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < CH; i++) begin
      idx = PTR_W'((int'(rr_q) + i) % CH);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // One-hot grant, suppressed when there is nothing to hand out
  always_comb begin
    gnt = '0;
    for (int c = 0; c < CH; c++) begin
      gnt[c] = found && en && (int'(win) == c);
    end
  end

  // Pointer moves just past the accepted winner
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = PTR_W'((int'(win) + 1) % CH);
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/payload_slot_pool.sv
// Tagged payload SRAM pool shared by CH allocation channels.
// Free slots live on a LIFO stack; a per-slot state bitmap validates
// read/update/free tags. Optional statistics (peak occupancy and
// allocation stall cycles) are built when PAYLOAD_STATS_EN is defined.
module payload_slot_pool
  import payload_pkg::*;
#(
  parameter int  SLOTS  = 64,
  parameter int  WIDTH  = 256,
  parameter int  CH     = 2,
  parameter int  LOW_WM = LOW_WM_DEFAULT,
  localparam int TAG_W  = tag_w(SLOTS),
  localparam int CNT_W  = TAG_W + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [CH-1:0]         alloc_valid,
  input  logic [CH*WIDTH-1:0]   alloc_data,
  output logic [CH-1:0]         alloc_ready,
  output logic [CH-1:0]         alloc_gnt,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic                  rd_req,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_err,
  input  logic                  upd_req,
  input  logic [TAG_W-1:0]      upd_tag,
  input  logic [WIDTH-1:0]      upd_data,
  input  logic [WIDTH/8-1:0]    upd_be,
  input  logic                  free_req,
  input  logic [TAG_W-1:0]      free_tag,
  output logic                  free_err,
  output logic [CNT_W-1:0]      used_count,
  output logic                  low_water,
  output logic [CNT_W-1:0]      peak_used,
  output logic [31:0]           stall_cycles
);

  localparam int PTR_W = (CH > 1) ? $clog2(CH) : 1;

  logic [WIDTH-1:0] mem_q   [SLOTS];
  logic [TAG_W-1:0] stack_q [SLOTS];
  logic [TAG_W-1:0] stack_d [SLOTS];
  slot_state_e      state_q [SLOTS];
  slot_state_e      state_d [SLOTS];
  logic [CNT_W-1:0] sp_q, sp_d;

  logic [CH-1:0]    alloc_gnt_q, alloc_gnt_d;
  logic [TAG_W-1:0] alloc_tag_q, alloc_tag_d;
  logic             rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_err_q, rd_err_d;
  logic             free_err_q, free_err_d;
  logic [CNT_W-1:0] used_count_q, used_count_d;
  logic             low_water_q, low_water_d;

  logic             have_free;
  logic             alloc_fire;
  logic [PTR_W-1:0] win_idx;
  logic [TAG_W-1:0] pop_tag;
  logic             free_ok;
  logic             upd_ok;
  logic             rd_hit;

  assign have_free  = (sp_q != '0);
  assign alloc_fire = |(alloc_valid & alloc_ready);
  assign pop_tag    = stack_q[TAG_W'(sp_q - 1'b1)];
  assign free_ok    = free_req && (state_q[free_tag] == SLOT_USED);
  assign upd_ok     = upd_req  && (state_q[upd_tag]  == SLOT_USED);
  assign rd_hit     = rd_req   && (state_q[rd_tag]   == SLOT_USED);

  payload_rr_arbiter #(
    .CH (CH)
  ) u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    (alloc_valid),
    .en     (have_free),
    .accept (alloc_fire),
    .gnt    (alloc_ready),
    .win    (win_idx)
  );

  // Free-stack and slot-state bookkeeping; a same-cycle alloc+free
  // overwrites the popped position so the pointer stays put
  always_comb begin
    stack_d = stack_q;
    state_d = state_q;
    sp_d    = sp_q;
    if (alloc_fire) begin
      state_d[pop_tag] = SLOT_USED;
    end
    if (free_ok) begin
      state_d[free_tag] = SLOT_FREE;
    end
    if (alloc_fire && free_ok) begin
      stack_d[TAG_W'(sp_q - 1'b1)] = free_tag;
    end else if (alloc_fire) begin
      sp_d = sp_q - 1'b1;
    end else if (free_ok) begin
      stack_d[TAG_W'(sp_q)] = free_tag;
      sp_d = sp_q + 1'b1;
    end
  end

  // Registered responses and occupancy reflecting the post-cycle state
  always_comb begin
    alloc_gnt_d  = alloc_fire ? alloc_ready : '0;
    alloc_tag_d  = alloc_fire ? pop_tag : '0;
    rd_valid_d   = rd_req;
    rd_err_d     = rd_req && !rd_hit;
    rd_data_d    = rd_hit ? mem_q[rd_tag] : '0;
    free_err_d   = free_req && !free_ok;
    used_count_d = CNT_W'(SLOTS) - sp_d;
    low_water_d  = (sp_d <= CNT_W'(LOW_WM));
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SLOTS; i++) begin
        stack_q[i] <= TAG_W'(SLOTS - 1 - i);
        state_q[i] <= SLOT_FREE;
      end
      sp_q         <= CNT_W'(SLOTS);
      alloc_gnt_q  <= '0;
      alloc_tag_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_err_q     <= 1'b0;
      free_err_q   <= 1'b0;
      used_count_q <= '0;
      low_water_q  <= 1'b0;
    end else begin
      stack_q      <= stack_d;
      state_q      <= state_d;
      sp_q         <= sp_d;
      alloc_gnt_q  <= alloc_gnt_d;
      alloc_tag_q  <= alloc_tag_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_err_q     <= rd_err_d;
      free_err_q   <= free_err_d;
      used_count_q <= used_count_d;
      low_water_q  <= low_water_d;
    end
  end

  // Payload storage: allocation fill and byte-masked update never share a tag
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      mem_q[pop_tag] <= alloc_data[int'(win_idx)*WIDTH +: WIDTH];
    end
    if (upd_ok) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (upd_be[b]) begin
          mem_q[upd_tag][b*8 +: 8] <= upd_data[b*8 +: 8];
        end
      end
    end
  end

  assign alloc_gnt  = alloc_gnt_q;
  assign alloc_tag  = alloc_tag_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign rd_err     = rd_err_q;
  assign free_err   = free_err_q;
  assign used_count = used_count_q;
  assign low_water  = low_water_q;

`ifdef PAYLOAD_STATS_EN
  logic [CNT_W-1:0] peak_used_q, peak_used_d;
  logic [31:0]      stall_cycles_q, stall_cycles_d;

  // Peak occupancy and saturating allocation-stall counter
  always_comb begin
    peak_used_d    = (used_count_d > peak_used_q) ? used_count_d : peak_used_q;
    stall_cycles_d = stall_cycles_q;
    if (|alloc_valid && !alloc_fire && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_used_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      peak_used_q    <= peak_used_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign peak_used    = peak_used_q;
  assign stall_cycles = stall_cycles_q;
`else
  assign peak_used    = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_payload_slot_pool.sv
// Directed self-checking bench for payload_slot_pool (default parameters).
module tb_payload_slot_pool;

  localparam int SLOTS = 64;
  localparam int WIDTH = 256;
  localparam int CH    = 2;
  localparam int TAG_W = 6;
  localparam int CNT_W = 7;

  logic                clk = 1'b0;
  logic                rstn;
  logic [CH-1:0]       alloc_valid;
  logic [CH*WIDTH-1:0] alloc_data;
  logic [CH-1:0]       alloc_ready;
  logic [CH-1:0]       alloc_gnt;
  logic [TAG_W-1:0]    alloc_tag;
  logic                rd_req;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_err;
  logic                upd_req;
  logic [TAG_W-1:0]    upd_tag;
  logic [WIDTH-1:0]    upd_data;
  logic [WIDTH/8-1:0]  upd_be;
  logic                free_req;
  logic [TAG_W-1:0]    free_tag;
  logic                free_err;
  logic [CNT_W-1:0]    used_count;
  logic                low_water;
  logic [CNT_W-1:0]    peak_used;
  logic [31:0]         stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  payload_slot_pool #(
    .SLOTS (SLOTS),
    .WIDTH (WIDTH),
    .CH    (CH)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .alloc_valid  (alloc_valid),
    .alloc_data   (alloc_data),
    .alloc_ready  (alloc_ready),
    .alloc_gnt    (alloc_gnt),
    .alloc_tag    (alloc_tag),
    .rd_req       (rd_req),
    .rd_tag       (rd_tag),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .upd_req      (upd_req),
    .upd_tag      (upd_tag),
    .upd_data     (upd_data),
    .upd_be       (upd_be),
    .free_req     (free_req),
    .free_tag     (free_tag),
    .free_err     (free_err),
    .used_count   (used_count),
    .low_water    (low_water),
    .peak_used    (peak_used),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = '0;
    alloc_data  = '0;
    rd_req      = 1'b0;
    rd_tag      = '0;
    upd_req     = 1'b0;
    upd_tag     = '0;
    upd_data    = '0;
    upd_be      = '0;
    free_req    = 1'b0;
    free_tag    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
  endtask

  // Allocate n slots on channel 0 with data equal to the expected tag
  task automatic fill_ch0(input int n);
    for (int k = 0; k < n; k++) begin
      alloc_valid = 2'b01;
      alloc_data  = '0;
      alloc_data[0 +: WIDTH] = WIDTH'(k);
      step();
    end
    alloc_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (used_count !== 7'd0) begin n_fail++; $display("FAIL reset_used_count: got %0d want 0", used_count); end
    n_checks++; if (low_water !== 1'b0) begin n_fail++; $display("FAIL reset_low_water: got %0b want 0", low_water); end
    n_checks++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_alloc_gnt: got %b want 00", alloc_gnt); end
    n_checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0 || free_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: rd_valid=%0b rd_err=%0b free_err=%0b want 0", rd_valid, rd_err, free_err); end
    n_checks++; if (peak_used !== 7'd0 || stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stats: peak=%0d stall=%0d want 0", peak_used, stall_cycles); end
    alloc_valid = 2'b10;
    #1;
    n_checks++; if (alloc_ready !== 2'b10) begin n_fail++; $display("FAIL reset_ready_ch1: got %b want 10", alloc_ready); end
    alloc_valid = '0;
    #1;
    n_checks++; if (alloc_ready !== 2'b00) begin n_fail++; $display("FAIL idle_ready: got %b want 00", alloc_ready); end
  endtask

  task automatic test_basic_alloc();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      alloc_valid = 2'b01;
      alloc_data  = '0;
      alloc_data[0 +: WIDTH] = WIDTH'(8'hA + k);
      step();
      n_checks++; if (alloc_gnt !== 2'b01) begin n_fail++; $display("FAIL basic_gnt[%0d]: got %b want 01", k, alloc_gnt); end
      n_checks++; if (alloc_tag !== TAG_W'(k)) begin n_fail++; $display("FAIL basic_tag[%0d]: got %0d want %0d", k, alloc_tag, k); end
    end
    alloc_valid = '0;
    n_checks++; if (used_count !== 7'd3) begin n_fail++; $display("FAIL basic_used: got %0d want 3", used_count); end
    rd_req = 1'b1;
    rd_tag = 6'd1;
    step();
    rd_req = 1'b0;
    n_checks++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL basic_gnt_pulse: got %b want 00", alloc_gnt); end
    n_checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b0) begin n_fail++; $display("FAIL basic_rd_flags: valid=%0b err=%0b want 1/0", rd_valid, rd_err); end
    n_checks++; if (rd_data !== WIDTH'(8'hB)) begin n_fail++; $display("FAIL basic_rd_data: got %h want b", rd_data); end
    step();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rd_pulse: got %0b want 0", rd_valid); end
  endtask

  task automatic test_round_robin();
    logic [CH-1:0] exp_gnt [4];
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    do_reset();
    alloc_valid = 2'b11;
    alloc_data  = '0;
    alloc_data[0 +: WIDTH]     = WIDTH'(16'h1111);
    alloc_data[WIDTH +: WIDTH] = WIDTH'(16'h2222);
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if (alloc_gnt !== exp_gnt[k]) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, alloc_gnt, exp_gnt[k]); end
      n_checks++; if (alloc_tag !== TAG_W'(k)) begin n_fail++; $display("FAIL rr_tag[%0d]: got %0d want %0d", k, alloc_tag, k); end
    end
    alloc_valid = '0;
    rd_req = 1'b1;
    rd_tag = 6'd1;
    step();
    n_checks++; if (rd_data !== WIDTH'(16'h2222)) begin n_fail++; $display("FAIL rr_rd_tag1: got %h want 2222", rd_data); end
    rd_tag = 6'd2;
    step();
    rd_req = 1'b0;
    n_checks++; if (rd_data !== WIDTH'(16'h1111)) begin n_fail++; $display("FAIL rr_rd_tag2: got %h want 1111", rd_data); end
  endtask

  task automatic test_full();
    do_reset();
    alloc_valid = 2'b01;
    alloc_data  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      step();
      if (i + 1 == 59) begin
        n_checks++; if (low_water !== 1'b0) begin n_fail++; $display("FAIL full_lw_59: got %0b want 0", low_water); end
      end
      if (i + 1 == 60) begin
        n_checks++; if (low_water !== 1'b1) begin n_fail++; $display("FAIL full_lw_60: got %0b want 1", low_water); end
      end
    end
    n_checks++; if (used_count !== 7'd64) begin n_fail++; $display("FAIL full_used: got %0d want 64", used_count); end
    n_checks++; if (alloc_ready !== 2'b00) begin n_fail++; $display("FAIL full_ready: got %b want 00", alloc_ready); end
    step();
    n_checks++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL full_no_gnt: got %b want 00", alloc_gnt); end
    free_req = 1'b1;
    free_tag = 6'd5;
    step();
    free_req = 1'b0;
    n_checks++; if (used_count !== 7'd63 || free_err !== 1'b0) begin n_fail++; $display("FAIL full_free5: used=%0d err=%0b want 63/0", used_count, free_err); end
    n_checks++; if (alloc_ready !== 2'b01) begin n_fail++; $display("FAIL full_ready_after_free: got %b want 01", alloc_ready); end
    step();
    alloc_valid = '0;
    n_checks++; if (alloc_gnt !== 2'b01 || alloc_tag !== 6'd5) begin n_fail++; $display("FAIL full_realloc: gnt=%b tag=%0d want 01/5", alloc_gnt, alloc_tag); end
    n_checks++; if (used_count !== 7'd64) begin n_fail++; $display("FAIL full_used_again: got %0d want 64", used_count); end
`ifdef PAYLOAD_STATS_EN
    n_checks++; if (peak_used !== 7'd64 || stall_cycles !== 32'd2) begin n_fail++; $display("FAIL full_stats: peak=%0d stall=%0d want 64/2", peak_used, stall_cycles); end
`else
    n_checks++; if (peak_used !== 7'd0 || stall_cycles !== 32'd0) begin n_fail++; $display("FAIL full_stats_off: peak=%0d stall=%0d want 0/0", peak_used, stall_cycles); end
`endif
  endtask

  task automatic test_double_free();
    do_reset();
    fill_ch0(8);
    free_req = 1'b1;
    free_tag = 6'd7;
    step();
    n_checks++; if (free_err !== 1'b0 || used_count !== 7'd7) begin n_fail++; $display("FAIL dfree_first: err=%0b used=%0d want 0/7", free_err, used_count); end
    step();
    free_req = 1'b0;
    n_checks++; if (free_err !== 1'b1 || used_count !== 7'd7) begin n_fail++; $display("FAIL dfree_second: err=%0b used=%0d want 1/7", free_err, used_count); end
    step();
    n_checks++; if (free_err !== 1'b0) begin n_fail++; $display("FAIL dfree_pulse: got %0b want 0", free_err); end
  endtask

  task automatic test_alloc_free_same();
    do_reset();
    fill_ch0(10);
    alloc_valid = 2'b01;
    free_req    = 1'b1;
    free_tag    = 6'd2;
    step();
    free_req = 1'b0;
    n_checks++; if (used_count !== 7'd10) begin n_fail++; $display("FAIL afs_used: got %0d want 10", used_count); end
    n_checks++; if (alloc_gnt !== 2'b01 || alloc_tag !== 6'd10) begin n_fail++; $display("FAIL afs_pop: gnt=%b tag=%0d want 01/10", alloc_gnt, alloc_tag); end
    step();
    alloc_valid = '0;
    n_checks++; if (alloc_tag !== 6'd2 || used_count !== 7'd11) begin n_fail++; $display("FAIL afs_reuse: tag=%0d used=%0d want 2/11", alloc_tag, used_count); end
  endtask

  task automatic test_update_read();
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    d0 = {8{32'hDEADBE01}};
    e1 = d0;
    e1[7:0] = 8'hFF;
    e2 = e1;
    e2[15:8] = 8'h5A;
    do_reset();
    alloc_valid = 2'b01;
    alloc_data  = '0;
    alloc_data[0 +: WIDTH] = d0;
    step();
    alloc_valid = '0;
    upd_req  = 1'b1;
    upd_tag  = 6'd0;
    upd_be   = '0;
    upd_be[0] = 1'b1;
    upd_data = WIDTH'(8'hFF);
    step();
    upd_req = 1'b0;
    rd_req  = 1'b1;
    rd_tag  = 6'd0;
    step();
    n_checks++; if (rd_data !== e1 || rd_err !== 1'b0) begin n_fail++; $display("FAIL upd_byte0: got %h err=%0b want %h", rd_data, rd_err, e1); end
    upd_req  = 1'b1;
    upd_be   = '0;
    upd_be[1] = 1'b1;
    upd_data = WIDTH'(16'h5A00);
    step();
    upd_req = 1'b0;
    n_checks++; if (rd_data !== e1) begin n_fail++; $display("FAIL upd_rd_same_cycle_old: got %h want %h", rd_data, e1); end
    step();
    n_checks++; if (rd_data !== e2) begin n_fail++; $display("FAIL upd_byte1: got %h want %h", rd_data, e2); end
    rd_tag = 6'd9;
    step();
    n_checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== '0) begin n_fail++; $display("FAIL rd_unalloc: valid=%0b err=%0b data=%h want 1/1/0", rd_valid, rd_err, rd_data); end
    rd_tag   = 6'd0;
    free_req = 1'b1;
    free_tag = 6'd0;
    step();
    free_req = 1'b0;
    n_checks++; if (rd_err !== 1'b0 || rd_data !== e2) begin n_fail++; $display("FAIL rd_free_same: err=%0b data=%h want 0/%h", rd_err, rd_data, e2); end
    n_checks++; if (used_count !== 7'd0) begin n_fail++; $display("FAIL rd_free_used: got %0d want 0", used_count); end
    step();
    rd_req = 1'b0;
    n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL rd_after_free: err=%0b want 1", rd_err); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    fill_ch0(2);
    rstn = 1'b0;
    #1;
    n_checks++; if (used_count !== 7'd0 || alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL async_reset: used=%0d gnt=%b want 0/00", used_count, alloc_gnt); end
    step();
    rstn = 1'b1;
    step();
    rd_req = 1'b1;
    rd_tag = 6'd0;
    alloc_valid = 2'b01;
    step();
    rd_req = 1'b0;
    alloc_valid = '0;
    n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL mid_reset_tag_invalid: err=%0b want 1", rd_err); end
    n_checks++; if (alloc_tag !== 6'd0 || alloc_gnt !== 2'b01) begin n_fail++; $display("FAIL mid_reset_first_tag: tag=%0d gnt=%b want 0/01", alloc_tag, alloc_gnt); end
  endtask

  initial begin
    rstn = 1'b1;
    idle_inputs();
    test_reset();
    test_basic_alloc();
    test_round_robin();
    test_full();
    test_double_free();
    test_alloc_free_same();
    test_update_read();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/payload_slot_pool.md
Name: payload_slot_pool

Overview:
Multi-channel successor to the single-port RT payload manager. It holds ray payloads for in-flight rays in a tagged SRAM pool. CH RT-core allocators share the pool through round-robin arbitration. Shader-side ports can read, update (byte-masked) and free slots, with tag-validity checking, occupancy tracking and a low-water flag. The block sits between the RT core traversal engine and the SM shader dispatch.

Parameters:
SLOTS, 64, number of payload slots (power of two, at least 4)
WIDTH, 256, payload width in bits (multiple of 8)
CH, 2, number of allocation channels (1..8)
LOW_WM, 4, low_water asserts when free slots are at or below this value

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous active-low
alloc_valid  in  CH  per-channel allocation request
alloc_data  in  CH*WIDTH  initial payload; channel c occupies bits [c*WIDTH +: WIDTH]
alloc_ready  out  CH  combinational, one-hot or zero; the request is accepted when valid and ready are both high
alloc_gnt  out  CH  registered one-hot pulse, one cycle after acceptance
alloc_tag  out  TAG_W  tag of the granted slot, valid with alloc_gnt (TAG_W = $clog2(SLOTS))
rd_req  in  1  read request
rd_tag  in  TAG_W  slot to read
rd_valid  out  1  read response pulse
rd_data  out  WIDTH  read payload
rd_err  out  1  the read tag was not allocated
upd_req  in  1  payload update request
upd_tag  in  TAG_W  slot to update
upd_data  in  WIDTH  update data
upd_be  in  WIDTH/8  byte enables
free_req  in  1  free request
free_tag  in  TAG_W  slot to free
free_err  out  1  pulse on a free of an unallocated tag
used_count  out  TAG_W+1  number of allocated slots
low_water  out  1  free slots are at or below LOW_WM
peak_used  out  TAG_W+1  statistics output (see Optional Feature)
stall_cycles  out  32  statistics output (see Optional Feature)

Behaviour:
- Reset: rstn is asynchronous and active-low; clk is the single clock.
  - Free stack is preloaded so tags pop in order 0,1,2,...
  - alloc_valid bitmap is cleared; used_count=0; rr pointer=0.
  - All outputs are 0 except low_water=0 (SLOTS>LOW_WM).
  - Memory contents are undefined after reset.
  - Reset asserted mid-operation discards all slots; outstanding tags become invalid.
- Arbitration:
  - The winner is the first requesting channel at or after rr, searching cyclically.
  - alloc_ready[winner]=1 only if the free count is nonzero.
  - On acceptance, rr becomes (winner+1) mod CH.
  - At most one allocation per cycle.
  - When the pool is full, all alloc_ready are 0 and requesters hold.
- Allocate:
  - The top of stack is popped.
  - mem[tag] is written with the winner's data and its bitmap bit is set.
  - alloc_gnt and alloc_tag are registered, giving 1-cycle latency.
- Read:
  - Latency is 1 cycle.
  - Unallocated tag: rd_data=0, rd_err=1, rd_valid=1.
  - Read and update of the same tag in the same cycle returns the old data.
- Update:
  - For each b, bytes with upd_be[b]=1 are written.
  - An update to an unallocated tag is dropped silently.
  - An update colliding with a same-cycle alloc of the same tag cannot occur, since the tag is unallocated.
- Free:
  - Allocated tag: push to the stack and clear its bitmap bit.
  - Unallocated tag (including double free): no push, free_err pulses for 1 cycle.
- Simultaneous events:
  - Alloc and free in the same cycle:
    - The popped tag is the old top.
    - The freed tag is written into that same stack position; the pointer is unchanged.
    - The freed tag is not reusable in that cycle; used_count is unchanged.
  - Read and free of the same tag in the same cycle: the read succeeds (rd_err=0).
  - Update and free of the same tag in the same cycle: the update is applied, then the slot is freed.
- Occupancy:
  - used_count and low_water are registered and reflect the post-cycle state.
  - used_count never exceeds SLOTS.

Optional Feature:
PAYLOAD_STATS_EN.
- When defined:
  - peak_used holds the maximum used_count since reset.
  - stall_cycles counts cycles in which any alloc_valid is high and no allocation is accepted; it saturates at 2^32-1.
- When undefined: both outputs are tied to 0 and no counter logic is generated.

Decomposition:
- Shared package payload_pkg: TAG_W derivation function, a slot-state enum (FREE/USED), and the LOW_WM default constant.
- One sub-module, payload_rr_arbiter: CH-wide round-robin with a rotating pointer, combinational grant and an update-on-accept input.

Test Plan:
- Reset, then channel 0 allocates 3 times with data 0xA,0xB,0xC -> tags 0,1,2 on alloc_gnt; used_count=3; rd_tag=1 -> rd_data=0xB, rd_err=0.
- CH=2, both channels request continuously for 4 cycles -> grants alternate ch0,ch1,ch0,ch1 with tags 0..3.
- Fill all 64 slots -> alloc_ready=0; low_water=1 from used_count=60; free tag 5 -> next alloc returns tag 5.
- Free tag 7 twice -> second free pulses free_err=1; used_count decrements only once.
- Alloc and free(tag 2) in the same cycle with 10 slots in use -> used_count stays 10; the popped tag is not 2; the next alloc returns 2.
- Update tag 0 with upd_be=0x0001, data 0xFF -> read returns the original data with byte 0 = 0xFF; read of unallocated tag 9 -> rd_err=1, rd_data=0.
